// File: rtl/seq_multiplier.sv
// Purpose: A x B multiplier, unsigned or two's-complement, with valid/ready on both sides.
// Latency: FAST path 1 cycle with throughput 1/cycle; ITER path B_WIDTH+1 cycles, one job at a time.
// Backpressure: product and out_valid hold while !out_ready; in_ready follows output occupancy (FAST) or idle state (ITER).
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand handshake; a and b are sampled only on accept
//   a [A_WIDTH]           operand a
//   b [B_WIDTH]           operand b
//   out_valid/out_ready   product handshake
//   product [A_WIDTH+B_WIDTH]  full-precision product
//   busy                  ITER: a job is in flight; FAST: output register occupied
//
// The path is chosen at elaboration: if either operand is narrower than
// FAST_THRESHOLD, a single registered multiply is used; otherwise an iterative
// shift-add engine is used that consumes one bit of b per cycle.
module seq_multiplier #(
    parameter int A_WIDTH        = 8,
    parameter int B_WIDTH        = 8,
    parameter int SIGNED         = 0,
    parameter int FAST_THRESHOLD = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [A_WIDTH-1:0]         a,
    input  logic [B_WIDTH-1:0]         b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [A_WIDTH+B_WIDTH-1:0] product,
    output logic                       busy
);

    localparam int PW       = A_WIDTH + B_WIDTH;
    localparam bit USE_FAST = (A_WIDTH < FAST_THRESHOLD) || (B_WIDTH < FAST_THRESHOLD);

    // Operand magnitudes. An A_WIDTH-bit unsigned magnitude is enough even for
    // the most negative value: -(-2^(A-1)) wraps to the bit pattern 2^(A-1),
    // which read as unsigned is exactly the magnitude.
    logic               neg_a;
    logic               neg_b;
    logic               neg_p;
    logic [A_WIDTH-1:0] mag_a;
    logic [B_WIDTH-1:0] mag_b;
    logic               accept;

    always_comb begin
        neg_a = (SIGNED != 0) && a[A_WIDTH-1];
        neg_b = (SIGNED != 0) && b[B_WIDTH-1];
        mag_a = neg_a ? -a : a;
        mag_b = neg_b ? -b : b;
        neg_p = neg_a ^ neg_b;
    end

    assign accept = in_valid && in_ready;

    generate
        if (USE_FAST) begin : g_fast
            logic [PW-1:0] mag_p;
            logic [PW-1:0] prod_d;
            logic [PW-1:0] prod_q;
            logic          vld_q;

            // The magnitude product always fits in PW bits, so multiplying at
            // PW width is exact.
            always_comb begin
                mag_p  = {{B_WIDTH{1'b0}}, mag_a} * {{A_WIDTH{1'b0}}, mag_b};
                prod_d = neg_p ? -mag_p : mag_p;
            end

            // A new accept takes priority: when the old product leaves in the
            // same cycle, the register simply reloads and out_valid stays high.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q  <= 1'b0;
                    prod_q <= '0;
                end else if (accept) begin
                    vld_q  <= 1'b1;
                    prod_q <= prod_d;
                end else if (out_ready) begin
                    vld_q  <= 1'b0;
                end
            end

            assign in_ready  = !vld_q || out_ready;
            assign out_valid = vld_q;
            assign product   = prod_q;
            assign busy      = vld_q;
        end else begin : g_iter
            localparam int CW = $clog2(B_WIDTH + 1);

            localparam logic [1:0] IDLE = 2'd0;
            localparam logic [1:0] BUSY = 2'd1;
            localparam logic [1:0] DONE = 2'd2;

            logic [1:0]         state;
            logic [CW-1:0]      cnt;
            logic [PW-1:0]      mag_a_q;   // shifted left one place per step
            logic [B_WIDTH-1:0] mag_b_q;   // shifted right; bit 0 is the current multiplier bit
            logic [PW-1:0]      acc;
            logic               neg_q;
            logic [PW-1:0]      prod_q;

            // BUSY runs B_WIDTH add steps (cnt 0..B_WIDTH-1) plus one final
            // cycle that applies the sign and registers the product, so
            // out_valid rises B_WIDTH+1 edges after the accept edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state   <= IDLE;
                    cnt     <= '0;
                    mag_a_q <= '0;
                    mag_b_q <= '0;
                    acc     <= '0;
                    neg_q   <= 1'b0;
                    prod_q  <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (accept) begin
                                mag_a_q <= {{B_WIDTH{1'b0}}, mag_a};
                                mag_b_q <= mag_b;
                                acc     <= '0;
                                cnt     <= '0;
                                neg_q   <= neg_p;
                                state   <= BUSY;
                            end
                        end
                        BUSY: begin
                            if (cnt == CW'(B_WIDTH)) begin
                                prod_q <= neg_q ? -acc : acc;
                                state  <= DONE;
                            end else begin
                                if (mag_b_q[0]) begin
                                    acc <= acc + mag_a_q;
                                end
                                mag_a_q <= mag_a_q << 1;
                                mag_b_q <= mag_b_q >> 1;
                                cnt     <= cnt + CW'(1);
                            end
                        end
                        DONE: begin
                            if (out_ready) begin
                                state <= IDLE;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end

            // No overlap: new operands are taken only once the previous
            // product has left, so DONE->IDLE and an accept never coincide.
            assign in_ready  = (state == IDLE);
            assign out_valid = (state == DONE);
            assign product   = prod_q;
            assign busy      = (state != IDLE);
        end
    endgenerate

endmodule
